// File: rtl/rot_seq_unit.sv
// Iterative WIDTH-bit rotator with valid/ready ports, one item in flight.
// Define ROT_FAST_EN to rotate two steps per cycle while at least two remain.
module rot_seq_unit #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             dir_q, dir_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic             accept;

  function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] d, input logic right);
    return right ? {d[0], d[WIDTH-1:1]} : {d[WIDTH-2:0], d[WIDTH-1]};
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = data_q;
  assign busy      = (state == SHIFT) || (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      dir_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      dir_q  <= dir_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    dir_nxt   = dir_q;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          data_nxt  = in_data;
          dir_nxt   = in_dir;
          cnt_nxt   = in_amt;
          state_nxt = (in_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
`ifdef ROT_FAST_EN
        if (cnt > AMT_W'(1)) begin
          data_nxt = rot1(rot1(data_q, dir_q), dir_q);
          cnt_nxt  = cnt - AMT_W'(2);
        end else begin
          data_nxt = rot1(data_q, dir_q);
          cnt_nxt  = cnt - AMT_W'(1);
        end
`else
        data_nxt = rot1(data_q, dir_q);
        cnt_nxt  = cnt - AMT_W'(1);
`endif
        if (cnt_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rot_seq_unit.sv
// Scoreboard bench for rot_seq_unit: expected word and latency queued at accept,
// popped when out_valid appears.
module tb_rot_seq_unit;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_dir, out_valid, out_ready, busy;
  logic [3:0] in_data, out_data;
  logic [1:0] in_amt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] d;
    int         lat;
  } exp_t;
  exp_t sb[$];

  rot_seq_unit #(.WIDTH(4), .AMT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dir(in_dir), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_lat(input int amt);
`ifdef ROT_FAST_EN
    return 1 + (amt + 1) / 2;
`else
    return 1 + amt;
`endif
  endfunction

  // Rotate by slicing a doubled word rather than stepping.
  function automatic logic [3:0] rot_model(input logic [3:0] d, input logic dir, input int amt);
    int         a;
    logic [7:0] w;
    a = dir ? (4 - (amt % 4)) % 4 : amt % 4;
    w = {d, d} << a;
    return w[7:4];
  endfunction

  task automatic run_item(input logic [3:0] d, input logic dir, input logic [1:0] amt,
                          input logic [3:0] exp_d, input int hold);
    exp_t       e;
    int         k;
    logic [3:0] held;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_amt   = amt;
    e.d   = exp_d;
    e.lat = exp_lat(int'(amt));
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_dir   = ~dir;
    in_amt   = amt + 2'd1;
    in_data  = ~d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!out_valid) chk("busy_in_flight", {busy, in_ready}, 2'b10);
    end while (!out_valid && k < 20);
    chk("out_valid_seen", out_valid, 1);
    e = sb.pop_front();
    chk("latency", k, e.lat);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        in_data  = 4'h5;
        in_amt   = 2'd1;
      end
      if (i == 3) in_valid = 1'b0;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, held);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("out_data", out_data, e.d);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  task automatic reset_abort();
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1000;
    in_dir   = 1'b1;
    in_amt   = 2'd3;
    e.d   = 4'b0001;
    e.lat = exp_lat(3);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1);
    chk("abort_out_valid_pre", out_valid, 0);
    rst = 1'b1;
    #1;
    chk("abort_in_ready_rst", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_front());
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_busy_clr", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_output", out_valid, 0);
    end
  endtask

  initial begin
    logic [3:0] d;
    logic       dir;
    logic [1:0] amt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_dir    = 1'b0;
    in_amt    = 2'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    run_item(4'b1011, 1'b0, 2'd1, 4'b0111, 0);
    run_item(4'b1011, 1'b1, 2'd2, 4'b1110, 0);
    run_item(4'b1000, 1'b1, 2'd3, 4'b0001, 0);
    run_item(4'b0110, 1'b0, 2'd0, 4'b0110, 0);
    run_item(4'b1101, 1'b0, 2'd2, 4'b0111, 5);
    reset_abort();
    run_item(4'b0011, 1'b1, 2'd1, 4'b1001, 1);

    for (int n = 0; n < 24; n++) begin
      d   = 4'($urandom_range(0, 15));
      dir = 1'($urandom_range(0, 1));
      amt = 2'($urandom_range(0, 3));
      run_item(d, dir, amt, rot_model(d, dir, int'(amt)), int'($urandom_range(0, 3)));
    end

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
